// File: rtl/parity_pkg.sv
// Shared types and constants for the even-parity serial transmitter.
// One frame: start bit, eight data bits (LSB first), parity bit, stop bit.
package parity_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even-parity bit of a byte: 1 when the byte holds an odd number of ones.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: tick is high on the last cycle of each CLKS_PER_BIT-cycle period.
// The counter wraps on tick so every bit or state change starts a fresh period.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned    CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/even_parity_serializer.sv
// Serial transmitter for a byte plus upstream-supplied even parity; flags parity
// disagreement on par_err but always sends the parity bit exactly as received.
module even_parity_serializer
    import parity_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 parity_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 par_err
);

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 par_err_q, par_err_d;
    logic [2:0]           idx_q, idx_d;
    logic                 tx_q, tx_d;
    logic                 tick;
    logic                 timer_clear;

    // Timer is held at zero while idle so START begins a full period.
    assign timer_clear = (state_q == IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(timer_clear),
        .tick (tick)
    );

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;
    assign par_err  = par_err_q;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_d     = par_q;
        par_err_d = par_err_q;
        idx_d     = idx_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = START;
                    data_d    = data_in;
                    par_d     = parity_in;
                    par_err_d = (parity_in != even_parity(data_in));
                    idx_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx is registered from next-state values so the line moves on the first START cycle.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
            idx_q     <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_q     <= par_d;
            par_err_q <= par_err_d;
            idx_q     <= idx_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: tb/tb_even_parity_serializer.sv
// Directed self-checking bench for even_parity_serializer with CLKS_PER_BIT = 4.
module tb_even_parity_serializer;

    localparam int unsigned CPB   = 4;
    localparam int          FRAME = 11 * CPB;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       parity_in;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       par_err;

    int checks;
    int errors;

    even_parity_serializer #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .parity_in(parity_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx       (tx),
        .busy     (busy),
        .par_err  (par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end just after a falling edge; inputs change and outputs
    // are sampled on falling edges, away from the rising (active) edge.

    task automatic test_reset();
        rst_n     = 1'b0;
        data_in   = 8'h00;
        parity_in = 1'b0;
        in_valid  = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err got %b want 0", par_err); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_idle_tx got %b want 1", tx); end
    endtask

    task automatic test_basic_frame();
        logic [10:0] f;
        f = {1'b1, 1'b0, 8'hA5, 1'b0};  // line order 0,1,0,1,0,0,1,0,1,0,1
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", in_ready); end
        data_in = 8'hA5; parity_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (tx !== f[i / CPB]) begin
                errors++; $display("FAIL basic_tx sample %0d got %b want %b", i, tx, f[i / CPB]);
            end
            checks++; if (busy !== 1'b1) begin
                errors++; $display("FAIL basic_busy sample %0d got %b want 1", i, busy);
            end
            checks++; if (par_err !== 1'b0) begin
                errors++; $display("FAIL basic_par_err sample %0d got %b want 0", i, par_err);
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_end_busy got %b want 0", busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL basic_end_tx got %b want 1", tx); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_end_ready got %b want 1", in_ready); end
    endtask

    task automatic test_par_err();
        logic [10:0] f;
        f = {1'b1, 1'b0, 8'h01, 1'b0};  // parity slot carries the wrong 0 as received
        data_in = 8'h01; parity_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (tx !== f[i / CPB]) begin
                errors++; $display("FAIL perr_tx sample %0d got %b want %b", i, tx, f[i / CPB]);
            end
            checks++; if (par_err !== 1'b1) begin
                errors++; $display("FAIL perr_flag sample %0d got %b want 1", i, par_err);
            end
        end
        @(negedge clk);
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL perr_hold got %b want 1", par_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL perr_end_busy got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] f1;
        logic [10:0] f2;
        f1 = {1'b1, 1'b0, 8'h00, 1'b0};
        f2 = {1'b1, 1'b0, 8'hFF, 1'b0};
        data_in = 8'h00; parity_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            data_in = 8'hFF;
            checks++; if (tx !== f1[i / CPB]) begin
                errors++; $display("FAIL b2b_tx1 sample %0d got %b want %b", i, tx, f1[i / CPB]);
            end
            checks++; if (in_ready !== 1'b0) begin
                errors++; $display("FAIL b2b_ready1 sample %0d got %b want 0", i, in_ready);
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap_ready got %b want 1", in_ready); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_gap_tx got %b want 1", tx); end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (tx !== f2[i / CPB]) begin
                errors++; $display("FAIL b2b_tx2 sample %0d got %b want %b", i, tx, f2[i / CPB]);
            end
            checks++; if (busy !== 1'b1) begin
                errors++; $display("FAIL b2b_busy2 sample %0d got %b want 1", i, busy);
            end
        end
        @(negedge clk);
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL b2b_par_err got %b want 0", par_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        logic [10:0] f;
        f = {1'b1, 1'b0, 8'h5A, 1'b0};
        data_in = 8'h3C; parity_in = 1'b1; in_valid = 1'b1;  // bad parity, so par_err must clear
        // Samples 16..19 are data bit 3; assert reset in the middle of it.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL rstmid_pre_perr got %b want 1", par_err); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL rstmid_perr got %b want 0", par_err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_resume got %b want 0", busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_idle_tx got %b want 1", tx); end
        data_in = 8'h5A; parity_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checks++; if (tx !== f[i / CPB]) begin
                errors++; $display("FAIL rstmid_tx2 sample %0d got %b want %b", i, tx, f[i / CPB]);
            end
            checks++; if (busy !== 1'b1) begin
                errors++; $display("FAIL rstmid_busy2 sample %0d got %b want 1", i, busy);
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_end_busy got %b want 0", busy); end
    endtask

    task automatic test_input_toggle();
        logic [10:0] f;
        f = {1'b1, 1'b0, 8'h96, 1'b0};
        data_in = 8'h96; parity_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            data_in   = ~data_in;
            parity_in = ~parity_in;
            in_valid  = (i < FRAME - 1) ? ~in_valid : 1'b0;
            checks++; if (tx !== f[i / CPB]) begin
                errors++; $display("FAIL toggle_tx sample %0d got %b want %b", i, tx, f[i / CPB]);
            end
        end
        @(negedge clk);
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL toggle_par_err got %b want 0", par_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_end_busy got %b want 0", busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_frame();
        test_par_err();
        test_back_to_back();
        test_reset_mid_frame();
        test_input_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/even_parity_serializer.md
EVEN_PARITY_SERIALIZER -- requirements
Module: even_parity_serializer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port data_in  input  8  byte to transmit.
REQ-005 SHALL have port parity_in  input  1  even-parity bit supplied by upstream generator for data_in.
REQ-006 SHALL have port in_valid  input  1  data_in/parity_in valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  registered serial line, idle high.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port par_err  output  1  registered; last accepted parity_in disagreed with even parity of its data_in.

Function
REQ-011 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-012 SHALL drive in_ready = 1 only in IDLE; busy = 1 in every state except IDLE.
REQ-013 SHALL accept on a cycle with in_valid && in_ready: latch data_in and parity_in, go to START.
REQ-014 SHALL hold each bit for exactly CLKS_PER_BIT cycles using a bit-period counter reset on every state or bit change.
REQ-015 SHALL drive tx: IDLE 1; START 0; DATA latched byte bit[idx], LSB first, idx 0..7; PARITY latched parity_in; STOP 1.
REQ-016 SHALL make tx change on the cycle after acceptance (first START cycle) and make a frame exactly 11*CLKS_PER_BIT cycles.
REQ-017 SHALL advance DATA -> PARITY only after bit 7 completes; STOP -> IDLE after its full period.
REQ-018 SHALL set par_err at acceptance to (parity_in != XOR of data_in bits), hold it until the next acceptance.
REQ-019 SHALL transmit latched parity_in unmodified even when par_err = 1 (no correction, no frame drop).
REQ-020 SHALL ignore data_in, parity_in and in_valid in all states except IDLE; latched values stay stable for the whole frame.
REQ-021 SHALL guarantee at least one IDLE cycle (tx = 1, in_ready = 1) between back-to-back frames.

Reset
REQ-022 SHALL on rst_n low, immediately and regardless of state: state IDLE, tx 1, busy 0, in_ready 1 once released, par_err 0, counters and latches 0.
REQ-023 SHALL abandon any partial frame on reset mid-operation; no resumption after release.

Structure
REQ-024 SHALL place state encoding typedef (IDLE..STOP), DATA_BITS = 8 and FRAME_BITS = 11 in shared package parity_pkg.
REQ-025 SHALL isolate bit-period counting in one sub-module bit_timer (parameter CLKS_PER_BIT; inputs clear; output tick on last cycle of a bit period).
REQ-026 SHALL size the bit-period counter as $clog2(CLKS_PER_BIT) bits and the bit index as 3 bits.

Verification (CLKS_PER_BIT = 4)
REQ-027 SHALL cover: accept 0xA5, parity_in 0 -> tx 0,1,0,1,0,0,1,0,1,0,1 each held 4 cycles, 44 busy cycles, par_err 0.
REQ-028 SHALL cover: accept 0x01, parity_in 0 -> par_err 1 from cycle after accept, parity slot on tx = 0, stop bit 1.
REQ-029 SHALL cover: in_valid held high with 0x00/0 then 0xFF/0 -> in_ready 0 during frame 1, exactly one IDLE cycle, frame 2 data bits all 1, parity 0.
REQ-030 SHALL cover: rst_n low during DATA bit 3 -> tx 1 and busy 0 same cycle; after release, next byte gives a complete clean frame.
REQ-031 SHALL cover: data_in toggled every cycle while busy -> transmitted bits equal the byte latched at acceptance.
